align_seq32: RTL and testbench
==============================

Name: align_seq32

Overview:
- Sequencer for the 32-bit iterative exponent-alignment unit in the FP add/sub path.
- Accepts an operand-exponent pair over a valid/ready handshake and strobes the aligner's load and enable.
- Counts the exact number of one-bit alignment steps (|eA − eB|, capped), then presents the common exponent and shift info downstream until taken.
- Sits between the operand-unpack stage and the mantissa add stage. Mantissas are wired from unpack to the aligner directly; this block controls only timing.

Parameters:
- MAX_SHIFT, 23: step cap. After 23 right shifts a 23-bit mantissa is zero, so further steps are pointless.
- CNT_W, 5: width of the step counter and of shift_cnt. Must hold MAX_SHIFT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  exponent pair and mantissas presented.
- in_ready  out  1  block can accept a pair.
- eA  in  8  exponent A, two's complement, same encoding the aligner uses.
- eB  in  8  exponent B, two's complement.
- flush  in  1  synchronous abort of the current operation.
- norm_load  out  1  aligner load strobe.
- norm_en  out  1  aligner enable.
- out_valid  out  1  aligned result available.
- out_ready  in  1  downstream accepts result.
- e_out  out  8  common exponent = signed max(eA, eB).
- shift_a  out  1  1 = A's mantissa was shifted (A had the smaller exponent).
- shift_cnt  out  CNT_W  steps actually performed.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: FSM goes to IDLE. out_valid=0, e_out=0, shift_a=0, shift_cnt=0, busy=0, step counter=0. in_ready, norm_load and norm_en are forced 0 while rst=1. Reset mid-operation abandons it with no output. Aligner contents are don't-care.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1 (when rst=0 and flush=0).
  - Accept = in_valid & in_ready. On accept, norm_load=1 and norm_en=1 combinationally in that same cycle, so the aligner loads at that edge.
  - At the accept edge: d = sext9(eA) − sext9(eB); N = min(|d|, MAX_SHIFT); shift_a = (d<0); e_out = (d<0) ? eB : eA; shift_cnt = N; counter = N.
  - Next state: SHIFT if N>0, else DONE.
- SHIFT:
  - norm_en=1, norm_load=0, in_ready=0. Counter decrements each cycle.
  - Leave for DONE on the edge where counter==1, giving exactly N enable cycles.
  - The aligner performs one step per enabled cycle, so its exponents converge after |d| steps. If capped, the shifted mantissa is already zero.
- DONE:
  - norm_en=0, so the aligner holds its mantissas. out_valid=1.
  - e_out, shift_a and shift_cnt are held stable.
  - On out_valid & out_ready: out_valid drops next cycle and FSM returns to IDLE. No new accept in that same cycle, because in_ready is 0 in DONE.
- Latency: with accept in cycle 0, out_valid first asserts in cycle N+1. Throughput is one pair per N+2 cycles minimum.
- Flush: priority is rst > flush > everything else.
  - flush=1 in SHIFT or DONE: next state IDLE, out_valid=0, counter=0, norm_en=0 in that cycle.
  - flush=1 in IDLE: blocks accept.
  - e_out, shift_a and shift_cnt are not cleared by flush.
- Arithmetic: 9-bit signed subtract, so no overflow for any 8-bit pair. |d| ranges 0..255 before the cap.
- Equal exponents: N=0, shift_a=0, norm_en high only in the load cycle.
- Outputs are stable while out_valid=1 and out_ready=0 (backpressure).

Test Plan:
- eA=5, eB=2, out_ready=1 → load cycle 0; norm_en high in cycles 1–3; out_valid cycle 4; e_out=5, shift_a=0, shift_cnt=3; aligner Bm = B>>3.
- eA=0xFD (−3), eB=4 → shift_cnt=7, shift_a=1, e_out=4; exactly 7 SHIFT enable cycles; out_valid cycle 8.
- eA=100, eB=0x9C (−100), |d|=200 → shift_cnt=23, out_valid cycle 24, aligner Bm=0; then eA=eB=0x10 → shift_cnt=0, out_valid cycle 1, norm_en only at load.
- Backpressure: eA=3, eB=1, out_ready held 0 for 5 cycles → out_valid, e_out=3 and shift_cnt=2 stable; in_ready=0 throughout; release → IDLE next cycle, in_ready=1.
- flush asserted in cycle 2 of a 10-step operation → IDLE next cycle, no out_valid, norm_en=0 from the flush cycle; next pair eA=1, eB=1 completes normally.
- rst pulsed during SHIFT with in_valid held high → in_ready=0, norm_en=0 during reset; IDLE after; all registered outputs at reset values; fresh accept proceeds.

Source files
------------

// File: rtl/align_seq32.sv
// Timing sequencer for the iterative exponent aligner: it accepts an exponent pair,
// strobes the aligner's load and enable for exactly min(|eA-eB|, MAX_SHIFT) steps, then holds the result.
module align_seq32 #(
  parameter int MAX_SHIFT = 23,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       eA,
  input  logic [7:0]       eB,
  input  logic             flush,
  output logic             norm_load,
  output logic             norm_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       e_out,
  output logic             shift_a,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Ready never depends on valid. Once valid is raised, it stays high until the transfer.
  // The data stays stable while valid is high.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [8:0]       diff;
  logic [8:0]       mag;
  logic [CNT_W-1:0] n_steps;

  // A 9-bit subtract covers every 8-bit two's-complement pair without overflow.
  assign diff    = {eA[7], eA} - {eB[7], eB};
  assign mag     = diff[8] ? (~diff + 9'd1) : diff;
  assign n_steps = (mag > 9'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : mag[CNT_W-1:0];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    norm_load = 1'b0;
    norm_en   = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            norm_load = 1'b1;
            norm_en   = 1'b1;
            cnt_nxt   = n_steps;
            state_nxt = (n_steps != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          norm_en = 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
        DONE: begin
          out_valid = 1'b1;
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      e_out     <= '0;
      shift_a   <= 1'b0;
      shift_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // norm_load is exactly the accept condition.
      if (norm_load) begin
        e_out     <= diff[8] ? eB : eA;
        shift_a   <= diff[8];
        shift_cnt <= n_steps;
      end
    end
  end

endmodule

// File: tb/tb_align_seq32.sv
// Directed and random checks of align_seq32, with a behavioural aligner attached to its strobes
// and a queue of expected results.
module tb_align_seq32;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, flush, norm_load, norm_en;
  logic       out_valid, out_ready, shift_a, busy;
  logic [7:0] eA, eB, e_out;
  logic [4:0] shift_cnt;

  logic [22:0] mant_a, mant_b, m_a, m_b;
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  align_seq32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .eA(eA), .eB(eB), .flush(flush), .norm_load(norm_load), .norm_en(norm_en),
    .out_valid(out_valid), .out_ready(out_ready), .e_out(e_out),
    .shift_a(shift_a), .shift_cnt(shift_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural aligner driven by the sequencer's strobes.
  always_ff @(posedge clk) begin
    if (norm_load) begin
      m_a <= mant_a;
      m_b <= mant_b;
    end else if (norm_en) begin
      if (shift_a) m_a <= m_a >> 1;
      else         m_b <= m_b >> 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pushes the model result, issues one pair and waits for the result (bounded).
  // The result is then held under backpressure for 'hold' cycles before it is released.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    int da, n, k, en_cycles;
    logic sa;
    logic [7:0] ee;
    logic [13:0] exp_w;
    logic [22:0] ma, mb, shifted;
    da = int'($signed(a)) - int'($signed(b));
    sa = (da < 0);
    n  = sa ? -da : da;
    if (n > 23) n = 23;
    ee = sa ? b : a;
    exp_q.push_back({ee, sa, 5'(n)});
    ma = 23'($urandom()) | 23'h400000;
    mb = 23'($urandom()) | 23'h400000;
    @(negedge clk);
    in_valid = 1'b1; eA = a; eB = b; mant_a = ma; mant_b = mb;
    out_ready = (hold == 0);
    #1;
    check("accept_ready", in_ready, 1);
    check("load_strobe", norm_load, 1);
    check("load_en", norm_en, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    k = 1;
    en_cycles = 0;
    while (!out_valid && k < 100) begin
      if (norm_en) en_cycles++;
      check("shift_no_ready", in_ready, 0);
      @(negedge clk);
      #1;
      k++;
    end
    check("latency", k, n + 1);
    check("en_cycles", en_cycles, n);
    exp_w = exp_q.pop_front();
    check("e_out", e_out, exp_w[13:6]);
    check("shift_a", shift_a, exp_w[5]);
    check("shift_cnt", shift_cnt, exp_w[4:0]);
    check("done_busy", busy, 1);
    check("done_en", norm_en, 0);
    shifted = (n >= 23) ? 23'd0 : ((sa ? ma : mb) >> n);
    check("mant_shifted", sa ? m_a : m_b, shifted);
    check("mant_kept", sa ? m_b : m_a, sa ? mb : ma);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_e_out", e_out, exp_w[13:6]);
      check("bp_cnt", shift_cnt, exp_w[4:0]);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("idle_valid", out_valid, 0);
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    eA = 8'd5; eB = 8'd2; mant_a = '0; mant_b = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_load", norm_load, 0);
    check("rst_en", norm_en, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_e_out", e_out, 0);
    check("rst_shift_a", shift_a, 0);
    check("rst_shift_cnt", shift_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_idle_ready", in_ready, 1);

    run_op(8'd5,   8'd2,   0);
    run_op(8'hFD,  8'd4,   0);
    run_op(8'd100, 8'h9C,  0);
    run_op(8'h10,  8'h10,  0);
    run_op(8'd3,   8'd1,   5);

    // A flush in IDLE blocks the accept.
    @(negedge clk);
    in_valid = 1'b1; eA = 8'd9; eB = 8'd0; flush = 1'b1;
    #1;
    check("flush_idle_ready", in_ready, 0);
    check("flush_idle_load", norm_load, 0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_busy", busy, 0);

    // A flush partway through a 10-step shift abandons it with no output.
    exp_q.push_back({8'd10, 1'b0, 5'd10});
    @(negedge clk);
    in_valid = 1'b1; eA = 8'd10; eB = 8'd0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("flush_pre_busy", busy, 1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_en", norm_en, 0);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", in_ready, 1);
    check("flush_busy", busy, 0);
    check("flush_keep_e_out", e_out, 10);
    check("flush_keep_cnt", shift_cnt, 10);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_output", seen, 0);
    run_op(8'd1, 8'd1, 0);

    // A reset during SHIFT, with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1; eA = 8'd0; eB = 8'd20;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", in_ready, 0);
    check("rst_mid_en", norm_en, 0);
    check("rst_mid_load", norm_load, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_e_out", e_out, 0);
    check("post_rst_shift_a", shift_a, 0);
    check("post_rst_cnt", shift_cnt, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ready", in_ready, 1);
    run_op(8'd7, 8'd9, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
